lifo_arbiter_ctrl: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the shared LIFO stack.
- Accepts push/pop requests from two clients and serialises them onto the LIFO's 6-bit command vector {push, pop, data[3:0]}.
- Tracks stack occupancy so overflow and underflow requests are rejected before reaching the stack.
- Returns popped data to the client that owns the pop.

---
 rtl/lifo_arbiter_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_lifo_arbiter_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_arbiter_ctrl.sv
// Two-client round-robin push/pop sequencer for the shared LIFO, with a shadow occupancy count.
// Optional LIFO_ARB_STATS_EN adds saturating push/pop/nack counters.
module lifo_arbiter_ctrl #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_push,
    input  logic              req0_pop,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_grant,
    output logic              req0_nack,
    input  logic              req1_push,
    input  logic              req1_pop,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_grant,
    output logic              req1_nack,
    output logic              rd_valid,
    output logic              rd_owner,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W+1:0] lifo_vector,
    input  logic [DATA_W-1:0] lifo_data_in,
    input  logic              lifo_empty,
    input  logic              lifo_full,
    output logic [CNT_W-1:0]  occupancy,
    output logic              flag_err
`ifdef LIFO_ARB_STATS_EN
    ,
    output logic [7:0]        push_cnt,
    output logic [7:0]        pop_cnt,
    output logic [7:0]        nack_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, POP_WAIT, POP_CAP} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    occ_q, occ_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   last_data_q, last_data_d;
    logic                issued_q, issued_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_owner_q, rd_owner_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                flag_err_q, flag_err_d;

    logic                req0, req1, sel;
    logic                sel_push, sel_pop;
    logic [DATA_W-1:0]   sel_data;
    logic                do_grant, do_nack, do_push, do_pop;
    logic [DATA_W+1:0]   vec;

    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        last_grant_d = last_grant_q;
        last_data_d  = last_data_q;
        issued_d     = 1'b0;
        rd_valid_d   = 1'b0;
        rd_owner_d   = rd_owner_q;
        rd_data_d    = rd_data_q;
        flag_err_d   = flag_err_q;
        do_grant     = 1'b0;
        do_nack      = 1'b0;
        do_push      = 1'b0;
        do_pop       = 1'b0;
        vec          = '0;

        req0     = req0_push | req0_pop;
        req1     = req1_push | req1_pop;
        sel      = (req0 && req1) ? ~last_grant_q : req1;
        sel_push = sel ? req1_push : req0_push;
        sel_pop  = sel ? req1_pop  : req0_pop;
        sel_data = sel ? req1_data : req0_data;

        unique case (state_q)
            IDLE: begin
                // flags lag one cycle behind an issued command
                if (!issued_q &&
                    ((lifo_full  != (occ_q == DEPTH_C)) ||
                     (lifo_empty != (occ_q == '0))))
                    flag_err_d = 1'b1;
                if (req0 || req1) begin
                    last_grant_d = sel;
                    if (sel_push && sel_pop) begin
                        do_nack = 1'b1;
                    end else if (sel_push && occ_q == DEPTH_C) begin
                        do_nack = 1'b1;
                    end else if (sel_pop && occ_q == '0) begin
                        do_nack = 1'b1;
                    end else if (sel_push) begin
                        do_grant    = 1'b1;
                        do_push     = 1'b1;
                        vec         = {2'b10, sel_data};
                        occ_d       = occ_q + ONE_C;
                        last_data_d = sel_data;
                        issued_d    = 1'b1;
                    end else begin
                        do_grant   = 1'b1;
                        do_pop     = 1'b1;
                        vec        = {2'b01, last_data_q};
                        occ_d      = occ_q - ONE_C;
                        issued_d   = 1'b1;
                        rd_owner_d = sel;
                        state_d    = POP_WAIT;
                    end
                end
            end
            POP_WAIT: state_d = POP_CAP;
            POP_CAP: begin
                rd_data_d  = lifo_data_in;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req0_grant  = do_grant & ~sel & ~reset;
        req1_grant  = do_grant &  sel & ~reset;
        req0_nack   = do_nack  & ~sel & ~reset;
        req1_nack   = do_nack  &  sel & ~reset;
        lifo_vector = reset ? '0 : vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            occ_q        <= '0;
            last_grant_q <= 1'b1;
            last_data_q  <= '0;
            issued_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_data_q    <= '0;
            flag_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            last_grant_q <= last_grant_d;
            last_data_q  <= last_data_d;
            issued_q     <= issued_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
            rd_data_q    <= rd_data_d;
            flag_err_q   <= flag_err_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_owner  = rd_owner_q;
    assign rd_data   = rd_data_q;
    assign occupancy = occ_q;
    assign flag_err  = flag_err_q;

`ifdef LIFO_ARB_STATS_EN
    logic [7:0] push_cnt_q, push_cnt_d;
    logic [7:0] pop_cnt_q, pop_cnt_d;
    logic [7:0] nack_cnt_q, nack_cnt_d;

    always_comb begin
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        nack_cnt_d = nack_cnt_q;
        if (do_push && push_cnt_q != 8'hFF) push_cnt_d = push_cnt_q + 8'd1;
        if (do_pop  && pop_cnt_q  != 8'hFF) pop_cnt_d  = pop_cnt_q  + 8'd1;
        if (do_nack && nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            nack_cnt_q <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            nack_cnt_q <= nack_cnt_d;
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign nack_cnt = nack_cnt_q;
`endif

endmodule

// File: tb/tb_lifo_arbiter_ctrl.sv
// Table-driven bench for lifo_arbiter_ctrl with a small behavioural LIFO on the command vector.
module tb_lifo_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_push, req0_pop, req1_push, req1_pop;
    logic [3:0] req0_data, req1_data;
    logic       req0_grant, req0_nack, req1_grant, req1_nack;
    logic       rd_valid, rd_owner;
    logic [3:0] rd_data;
    logic [5:0] lifo_vector;
    logic [3:0] lifo_data_in;
    logic       lifo_empty, lifo_full;
    logic [3:0] occupancy;
    logic       flag_err;
`ifdef LIFO_ARB_STATS_EN
    logic [7:0] push_cnt, pop_cnt, nack_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lifo_arbiter_ctrl dut (
        .clk(clk), .reset(reset),
        .req0_push(req0_push), .req0_pop(req0_pop),
        .req0_data(req0_data),
        .req0_grant(req0_grant), .req0_nack(req0_nack),
        .req1_push(req1_push), .req1_pop(req1_pop),
        .req1_data(req1_data),
        .req1_grant(req1_grant), .req1_nack(req1_nack),
        .rd_valid(rd_valid), .rd_owner(rd_owner),
        .rd_data(rd_data), .lifo_vector(lifo_vector),
        .lifo_data_in(lifo_data_in),
        .lifo_empty(lifo_empty), .lifo_full(lifo_full),
        .occupancy(occupancy), .flag_err(flag_err)
`ifdef LIFO_ARB_STATS_EN
        ,
        .push_cnt(push_cnt), .pop_cnt(pop_cnt),
        .nack_cnt(nack_cnt)
`endif
    );

    // behavioural LIFO: registered data_out loads on pop
    logic [3:0] mem [0:7];
    logic [3:0] sp;
    logic [3:0] dout;
    logic       force_full;

    always @(posedge clk) begin
        if (reset) begin
            sp   <= '0;
            dout <= '0;
        end else if (lifo_vector[5]) begin
            mem[sp[2:0]] <= lifo_vector[3:0];
            sp <= sp + 4'd1;
        end else if (lifo_vector[4]) begin
            dout <= mem[3'(sp - 4'd1)];
            sp <= sp - 4'd1;
        end
    end

    assign lifo_data_in = dout;
    assign lifo_empty   = (sp == 4'd0);
    assign lifo_full    = (sp == 4'd8) | force_full;

    typedef struct {
        logic       p0, q0;
        logic [3:0] d0;
        logic       p1, q1;
        logic [3:0] d1;
        logic [3:0] gn;
        logic [5:0] vec;
        logic       rv, ro;
        logic [3:0] rd;
        logic [3:0] occ;
    } row_t;

    row_t tbl [29];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic p0, input logic q0,
                         input logic [3:0] d0, input logic p1,
                         input logic q1, input logic [3:0] d1);
        req0_push = p0; req0_pop = q0; req0_data = d0;
        req1_push = p1; req1_pop = q1; req1_data = d1;
    endtask

    function automatic logic [3:0] gn();
        return {req0_grant, req0_nack, req1_grant, req1_nack};
    endfunction

    initial begin
        // {g0,n0,g1,n1} in gn
        tbl[0]  = '{1,0,4'hF, 0,0,4'h0, 4'b1000, 6'h2F, 0,0,4'h0, 4'd1};
        tbl[1]  = '{1,0,4'hE, 0,0,4'h0, 4'b1000, 6'h2E, 0,0,4'h0, 4'd2};
        tbl[2]  = '{1,0,4'hD, 0,0,4'h0, 4'b1000, 6'h2D, 0,0,4'h0, 4'd3};
        tbl[3]  = '{1,0,4'h9, 0,0,4'h0, 4'b1000, 6'h29, 0,0,4'h0, 4'd4};
        tbl[4]  = '{0,0,4'h0, 0,1,4'h0, 4'b0010, 6'h19, 0,0,4'h0, 4'd3};
        tbl[5]  = '{0,0,4'h0, 0,1,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd3};
        tbl[6]  = '{0,0,4'h0, 0,1,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd3};
        tbl[7]  = '{0,0,4'h0, 0,1,4'h0, 4'b0010, 6'h19, 1,1,4'h9, 4'd2};
        tbl[8]  = '{0,0,4'h0, 0,1,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd2};
        tbl[9]  = '{0,0,4'h0, 0,1,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd2};
        tbl[10] = '{0,0,4'h0, 0,1,4'h0, 4'b0010, 6'h19, 1,1,4'hD, 4'd1};
        tbl[11] = '{0,0,4'h0, 0,1,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd1};
        tbl[12] = '{0,0,4'h0, 0,1,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd1};
        tbl[13] = '{0,0,4'h0, 0,1,4'h0, 4'b0010, 6'h19, 1,1,4'hE, 4'd0};
        tbl[14] = '{0,0,4'h0, 0,0,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd0};
        tbl[15] = '{0,0,4'h0, 0,0,4'h0, 4'b0000, 6'h00, 0,0,4'h0, 4'd0};
        tbl[16] = '{0,0,4'h0, 0,0,4'h0, 4'b0000, 6'h00, 1,1,4'hF, 4'd0};
        tbl[17] = '{0,1,4'h0, 0,0,4'h0, 4'b0100, 6'h00, 0,0,4'h0, 4'd0};
        tbl[18] = '{0,0,4'h0, 1,1,4'h5, 4'b0001, 6'h00, 0,0,4'h0, 4'd0};
        for (int i = 19; i <= 26; i++) begin
            if (i % 2 == 1)
                tbl[i] = '{1,0,4'h0, 1,0,4'h1, 4'b1000, 6'h20,
                           0,0,4'h0, 4'(i - 18)};
            else
                tbl[i] = '{1,0,4'h0, 1,0,4'h1, 4'b0010, 6'h21,
                           0,0,4'h0, 4'(i - 18)};
        end
        tbl[27] = '{1,0,4'h3, 0,0,4'h0, 4'b0100, 6'h00, 0,0,4'h0, 4'd8};
        tbl[28] = '{1,0,4'h3, 1,0,4'h4, 4'b0001, 6'h00, 0,0,4'h0, 4'd8};

        force_full = 1'b0;
        reset = 1'b1;
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gn", 32'(gn()), 32'h0);
        chk("reset_vec", 32'(lifo_vector), 32'h0);
        chk("reset_occ", 32'(occupancy), 32'h0);
        chk("reset_rv", 32'(rd_valid), 32'h0);
        chk("reset_rd", 32'({rd_owner, rd_data}), 32'h0);
        chk("reset_err", 32'(flag_err), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].p0, tbl[i].q0, tbl[i].d0,
                  tbl[i].p1, tbl[i].q1, tbl[i].d1);
            #1;
            chk($sformatf("row%0d_gn", i), 32'(gn()), 32'(tbl[i].gn));
            chk($sformatf("row%0d_vec", i), 32'(lifo_vector),
                32'(tbl[i].vec));
            chk($sformatf("row%0d_rv", i), 32'(rd_valid),
                32'(tbl[i].rv));
            if (tbl[i].rv)
                chk($sformatf("row%0d_rd", i), 32'({rd_owner, rd_data}),
                    32'({tbl[i].ro, tbl[i].rd}));
            @(negedge clk);
            chk($sformatf("row%0d_occ", i), 32'(occupancy),
                32'(tbl[i].occ));
            if (i == 16)
                chk("empty_after_pops", 32'(lifo_empty), 32'h1);
        end
        chk("no_flag_err", 32'(flag_err), 32'h0);
`ifdef LIFO_ARB_STATS_EN
        chk("push_cnt", 32'(push_cnt), 32'd12);
        chk("pop_cnt", 32'(pop_cnt), 32'd4);
        chk("nack_cnt", 32'(nack_cnt), 32'd4);
`endif

        // reset while the pop is in POP_WAIT
        drive(0, 1, 4'h0, 0, 0, 4'h0);
        #1;
        chk("rstpop_gn", 32'(gn()), 32'b1000);
        chk("rstpop_vec", 32'(lifo_vector), 32'h11);
        @(negedge clk);
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstpop_occ", 32'(occupancy), 32'h0);
        chk("rstpop_vec0", 32'(lifo_vector), 32'h0);
        chk("rstpop_gn0", 32'(gn()), 32'h0);
        chk("rstpop_rd", 32'({rd_valid, rd_owner, rd_data}), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rstpop_rv%0d", k), 32'(rd_valid), 32'h0);
        end
`ifdef LIFO_ARB_STATS_EN
        chk("cnt_after_reset", 32'({push_cnt, pop_cnt, nack_cnt}), 32'h0);
`endif

        // three pushes, then disagree full flag at occupancy 3
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 4'(k + 1), 0, 0, 4'h0);
            #1;
            chk($sformatf("fpush%0d_gn", k), 32'(gn()), 32'b1000);
            @(negedge clk);
        end
        drive(0, 0, 4'h0, 0, 0, 4'h0);
        chk("fpush_occ", 32'(occupancy), 32'd3);
        force_full = 1'b1;
        repeat (2) @(negedge clk);
        chk("flag_err_set", 32'(flag_err), 32'h1);
        force_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("flag_err_sticky", 32'(flag_err), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("flag_err_clr", 32'(flag_err), 32'h0);
        chk("flag_occ_clr", 32'(occupancy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
